cp0_regfile: RTL

//  MIPS CP0 register file: the state holder on the other end of the WB exception detector.

---
 rtl/cp0_regfile_pkg.sv | 48 ++++
 rtl/cp0_regfile_timer.sv | 78 +++++++
 rtl/cp0_regfile.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cp0_regfile_pkg.sv
// CP0 shared definitions: register numbers, exception codes, field positions.
package cp0_defs;

    // CP0 register numbers served by mfc0/mtc0
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // Exception codes recorded in Cause.ExcCode
    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_OV   = 5'h0c
    } exccode_e;

    // Status field positions
    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_IM_LO   = 8;
    localparam int STATUS_IM_HI   = 15;

    // Cause field positions
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_EXC_HI  = 6;
    localparam int CAUSE_IPS_LO  = 8;
    localparam int CAUSE_IPS_HI  = 9;
    localparam int CAUSE_IPH_LO  = 10;
    localparam int CAUSE_IPH_HI  = 15;
    localparam int CAUSE_TI_BIT  = 30;
    localparam int CAUSE_BD_BIT  = 31;

    // Status bits that software may change; the rest are fixed at reset value
    localparam logic [31:0] STATUS_WMASK         = 32'h0000_FF03;
    localparam logic [31:0] STATUS_RESET_DEFAULT = 32'h0040_0000;

    // Address-error exceptions are the only ones that capture BadVAddr
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare, and the sticky timer interrupt.
module cp0_timer
    import cp0_defs::*;
#(
    parameter int TICK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_q,    tick_d;
    logic [31:0]   count_q,   count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ti_q,      ti_d;

    // Next-state for prescaler, Count, Compare and TI
    always_comb begin
        tick_d    = tick_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        // A software load of Count restarts the prescale period
        if (count_we) begin
            count_d = wdata;
            tick_d  = '0;
        end else if (tick_q == TICK_LAST) begin
            count_d = count_q + 32'd1;
            tick_d  = '0;
        end else begin
            tick_d  = tick_q + TW'(1);
        end

        if (compare_we) begin
            compare_d = wdata;
        end else begin
            compare_d = compare_q;
        end

        // Writing Compare acknowledges the timer interrupt, even against a match
        if (compare_we) begin
            ti_d = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end else begin
            ti_d = ti_q;
        end
    end

    // Timer state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q    <= '0;
            count_q   <= 32'h0000_0000;
            compare_q <= 32'h0000_0000;
            ti_q      <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: exception/eret commit, mtc0/mfc0 access, interrupt pending.
module cp0_regfile
    import cp0_defs::*;
#(
    parameter int          TICK_DIV     = 2,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic        exception_occur,
    input  logic [4:0]  ExcCode_in,
    input  logic        is_bd,
    input  logic [31:0] epc_in,
    input  logic [31:0] badvaddr_in,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic [31:0] Status,
    output logic [31:0] Cause,
    output logic [31:0] EPC,
    output logic [31:0] Count,
    output logic        int_pending
);

    logic        wr_status_s, wr_cause_s, wr_epc_s, wr_count_s, wr_compare_s;
    logic [31:0] compare_s;
    logic        ti_s;

    logic [7:0]  im_q,       im_d;
    logic        exl_q,      exl_d;
    logic        ie_q,       ie_d;
    logic        bd_q,       bd_d;
    logic [5:0]  ip_hw_q,    ip_hw_d;
    logic [1:0]  ip_sw_q,    ip_sw_d;
    logic [4:0]  exc_q,      exc_d;
    logic [31:0] epc_q,      epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    assign wr_status_s  = we && (waddr == REG_STATUS);
    assign wr_cause_s   = we && (waddr == REG_CAUSE);
    assign wr_epc_s     = we && (waddr == REG_EPC);
    assign wr_count_s   = we && (waddr == REG_COUNT);
    assign wr_compare_s = we && (waddr == REG_COMPARE);

    cp0_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr_count_s),
        .compare_we (wr_compare_s),
        .wdata      (wdata),
        .count      (Count),
        .compare    (compare_s),
        .ti         (ti_s)
    );

    // Next-state for Status/Cause/EPC/BadVAddr; exception beats eret beats mtc0
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        exc_d      = exc_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        // IM and IE are untouched by exception/eret, so mtc0 always lands there
        if (wr_status_s) begin
            im_d = wdata[STATUS_IM_HI:STATUS_IM_LO];
            ie_d = wdata[STATUS_IE_BIT];
        end else begin
            im_d = im_q;
            ie_d = ie_q;
        end

        if (wr_cause_s) begin
            ip_sw_d = wdata[CAUSE_IPS_HI:CAUSE_IPS_LO];
        end else begin
            ip_sw_d = ip_sw_q;
        end

        // Hardware lines are sampled every cycle; TI is folded onto line 5
        ip_hw_d = {hw_int[5] | ti_s, hw_int[4:0]};

        if (exception_occur) begin
            exl_d = 1'b1;
            exc_d = ExcCode_in;
            // A nested exception keeps the original return point
            if (!exl_q) begin
                epc_d = is_bd ? (epc_in - 32'd4) : epc_in;
                bd_d  = is_bd;
            end else begin
                epc_d = epc_q;
                bd_d  = bd_q;
            end
            if (is_addr_exc(ExcCode_in)) begin
                badvaddr_d = badvaddr_in;
            end else begin
                badvaddr_d = badvaddr_q;
            end
        end else if (eret) begin
            exl_d = 1'b0;
            if (wr_epc_s) begin
                epc_d = wdata;
            end else begin
                epc_d = epc_q;
            end
        end else begin
            if (wr_status_s) begin
                exl_d = wdata[STATUS_EXL_BIT];
            end else begin
                exl_d = exl_q;
            end
            if (wr_epc_s) begin
                epc_d = wdata;
            end else begin
                epc_d = epc_q;
            end
        end
    end

    // Architectural register state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            im_q       <= STATUS_RESET[STATUS_IM_HI:STATUS_IM_LO];
            exl_q      <= STATUS_RESET[STATUS_EXL_BIT];
            ie_q       <= STATUS_RESET[STATUS_IE_BIT];
            bd_q       <= 1'b0;
            ip_hw_q    <= 6'b00_0000;
            ip_sw_q    <= 2'b00;
            exc_q      <= 5'h00;
            epc_q      <= 32'h0000_0000;
            badvaddr_q <= 32'h0000_0000;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exc_q      <= exc_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // Assemble architectural views of the registers and the interrupt request
    always_comb begin
        Status = (STATUS_RESET & ~STATUS_WMASK)
               | {16'h0000, im_q, 6'b00_0000, exl_q, ie_q};
        Cause  = {bd_q, ti_s, 14'h0000, ip_hw_q, ip_sw_q, 1'b0, exc_q, 2'b00};
        EPC    = epc_q;
        int_pending = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));
    end

    // mfc0 read mux: current register values, no write bypass
    always_comb begin
        case (raddr)
            REG_BADVADDR: rdata = badvaddr_q;
            REG_COUNT:    rdata = Count;
            REG_COMPARE:  rdata = compare_s;
            REG_STATUS:   rdata = Status;
            REG_CAUSE:    rdata = Cause;
            REG_EPC:      rdata = epc_q;
            default:      rdata = 32'h0000_0000;
        endcase
    end

endmodule
